// File: rtl/rr_mux_if.sv
// Requester/consumer bundle for the round-robin mux arbiter: N request lanes in,
// one muxed stream out, plus the registered grant.
interface rr_mux_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic [NUM_REQ-1:0]        last_i;
  logic                      ready_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic                      valid_o;
  logic [DATA_W-1:0]         data_o;
  logic                      last_o;
  logic                      busy_o;

  modport master (
    output req_i, data_i, last_i, ready_i,
    input  gnt_o, valid_o, data_o, last_o, busy_o
  );

  modport slave (
    input  req_i, data_i, last_i, ready_i,
    output gnt_o, valid_o, data_o, last_o, busy_o
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning an N:1 and-or mux; the registered one-hot grant is
// held for a whole packet and drives the mux select directly.
module rr_mux_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  rr_mux_if.slave     bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, pick;
  logic [PTR_W-1:0]   ptr_q, ptr_d, gnt_idx;
  logic [DATA_W-1:0]  mux_data;
  logic               valid, last;

  // Walk from farthest to nearest so the candidate closest after ptr wins.
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_i[(int'(ptr_q) + k) % NUM_REQ]) begin
        pick = '0;
        pick[(int'(ptr_q) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) gnt_idx = PTR_W'(i);
    end
  end

  // And-or mux: a zero grant forces every output lane to zero.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mux_data |= bus.data_i[i*DATA_W +: DATA_W] & {DATA_W{gnt_q[i]}};
    end
  end

  assign valid = |(bus.req_i & gnt_q);
  assign last  = (|(bus.last_i & gnt_q)) & valid;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          gnt_d   = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (valid && bus.ready_i && last) begin
          gnt_d   = '0;
          ptr_d   = gnt_idx;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.valid_o = valid;
  assign bus.data_o  = mux_data;
  assign bus.last_o  = last;
  assign bus.busy_o  = (state_q == GRANT);
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: stimulus queues expected beats, a monitor
// pops and compares them on every accepted transfer.
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] dat;

  rr_mux_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  rr_mux_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] d, input logic l);
    beat_t b;
    b.gnt = g; b.data = d; b.last = l;
    exp_q.push_back(b);
  endtask

  // One cycle: drive just after the rising edge, check grant/busy on the falling edge.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic [3:0] lst,
                     input logic rdy, input logic [3:0] exp_gnt);
    @(posedge clk);
    #1;
    reset       = rst;
    bus.req_i   = req;
    bus.last_i  = lst;
    bus.ready_i = rdy;
    bus.data_i  = dat;
    @(negedge clk);
    check("gnt", 32'(bus.gnt_o), 32'(exp_gnt));
    check("busy", 32'(bus.busy_o), 32'(exp_gnt != 4'b0));
  endtask

  // Scoreboard monitor plus the zero-grant invariant.
  always @(negedge clk) begin
    beat_t b;
    check("gnt_onehot0", 32'($onehot0(bus.gnt_o)), 32'd1);
    if (bus.gnt_o == 4'b0) begin
      check("idle_valid", 32'(bus.valid_o), 32'd0);
      check("idle_last",  32'(bus.last_o),  32'd0);
      check("idle_data",  32'(bus.data_o),  32'd0);
    end
    if (!reset && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(bus.gnt_o), 32'd0);
      end else begin
        b = exp_q.pop_front();
        check("beat_gnt",  32'(bus.gnt_o),  32'(b.gnt));
        check("beat_data", 32'(bus.data_o), 32'(b.data));
        check("beat_last", 32'(bus.last_o), 32'(b.last));
      end
    end
  end

  logic [3:0] t1_gnt [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
  logic [7:0] t1_dat [10] = '{8'h00, 8'h10, 8'h00, 8'h11, 8'h00, 8'h12, 8'h00, 8'h13, 8'h00, 8'h10};

  initial begin
    reset       = 1'b1;
    bus.req_i   = 4'hF;
    bus.last_i  = 4'hF;
    bus.ready_i = 1'b1;
    dat         = 32'h13121110;
    bus.data_i  = dat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",   32'(bus.gnt_o),   32'd0);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_busy",  32'(bus.busy_o),  32'd0);
    check("rst_last",  32'(bus.last_o),  32'd0);
    check("rst_data",  32'(bus.data_o),  32'd0);

    // All requesting, single-beat packets: rotation 0,1,2,3,0 with a bubble between.
    for (int c = 0; c < 10; c++) begin
      if (t1_gnt[c] != 4'h0) push(t1_gnt[c], t1_dat[c], 1'b1);
      cyc(1'b0, 4'hF, 4'hF, 1'b1, t1_gnt[c]);
    end
    cyc(1'b0, 4'h0, 4'h0, 1'b1, 4'h0);

    // Three-beat packet on requester 2.
    dat[23:16] = 8'hA1;
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 4'h0);
    push(4'b0100, 8'hA1, 1'b0);
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100);
    dat[23:16] = 8'hA2;
    push(4'b0100, 8'hA2, 1'b0);
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100);
    dat[23:16] = 8'hA3;
    push(4'b0100, 8'hA3, 1'b1);
    cyc(1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100);
    cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 4'h0);

    // Same packet with a two-cycle downstream stall on beat 2.
    dat[23:16] = 8'hA1;
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 4'h0);
    push(4'b0100, 8'hA1, 1'b0);
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100);
    dat[23:16] = 8'hA2;
    for (int s = 0; s < 2; s++) begin
      cyc(1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100);
      check("stall_valid", 32'(bus.valid_o), 32'd1);
      check("stall_data",  32'(bus.data_o),  32'hA2);
      check("stall_last",  32'(bus.last_o),  32'd0);
    end
    push(4'b0100, 8'hA2, 1'b0);
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100);
    dat[23:16] = 8'hA3;
    push(4'b0100, 8'hA3, 1'b1);
    cyc(1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100);
    cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 4'h0);

    // Requester 1 pauses mid-packet while requester 3 waits with last asserted.
    dat = 32'hC0A3B1A1;
    cyc(1'b0, 4'b0010, 4'b0000, 1'b1, 4'h0);
    push(4'b0010, 8'hB1, 1'b0);
    cyc(1'b0, 4'b1010, 4'b0000, 1'b1, 4'b0010);
    for (int s = 0; s < 3; s++) begin
      cyc(1'b0, 4'b1000, 4'b1000, 1'b1, 4'b0010);
      check("gap_valid", 32'(bus.valid_o), 32'd0);
      check("gap_last",  32'(bus.last_o),  32'd0);
    end
    dat[15:8] = 8'hB2;
    push(4'b0010, 8'hB2, 1'b1);
    cyc(1'b0, 4'b1010, 4'b1010, 1'b1, 4'b0010);
    cyc(1'b0, 4'b1000, 4'b1000, 1'b1, 4'h0);
    push(4'b1000, 8'hC0, 1'b1);
    cyc(1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1000);

    // Wrap: after 3 the scan starts at 0; after 0, requester 3 beats 0.
    cyc(1'b0, 4'b1001, 4'b1001, 1'b1, 4'h0);
    push(4'b0001, 8'hA1, 1'b1);
    cyc(1'b0, 4'b1001, 4'b1001, 1'b1, 4'b0001);
    cyc(1'b0, 4'b1001, 4'b1001, 1'b1, 4'h0);
    push(4'b1000, 8'hC0, 1'b1);
    cyc(1'b0, 4'b1001, 4'b1001, 1'b1, 4'b1000);
    cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 4'h0);

    // Reset on beat 2 of a packet aborts it and restores requester-0 priority.
    dat[23:16] = 8'hD1;
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 4'h0);
    push(4'b0100, 8'hD1, 1'b0);
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100);
    dat[23:16] = 8'hD2;
    cyc(1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0100);
    dat[15:8] = 8'hE1;
    cyc(1'b0, 4'b0110, 4'b0000, 1'b1, 4'h0);
    check("post_rst_valid", 32'(bus.valid_o), 32'd0);
    push(4'b0010, 8'hE1, 1'b1);
    cyc(1'b0, 4'b0110, 4'b0110, 1'b1, 4'b0010);
    cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 4'h0);

    @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one N:1 one-hot select mux between N requesters streaming packets to a single downstream consumer.
- Registers a one-hot grant and holds it for a whole packet, ending on the beat that carries last.
- Drives the grant straight into an and-or mux select, so the output is always 0 when no grant is held.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- DATA_W, 8, data width per requester.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester valid; bit i asserted means requester i presents a beat.
- data_i  input  NUM_REQ*DATA_W  packed data; slice i is data_i[i*DATA_W +: DATA_W].
- last_i  input  NUM_REQ  per-requester end-of-packet flag, qualified by req_i[i].
- ready_i  input  1  downstream ready.
- gnt_o  output  NUM_REQ  registered one-hot grant, equal to the mux select; all zero when idle.
- valid_o  output  1  downstream valid.
- data_o  output  DATA_W  muxed data.
- last_o  output  1  muxed last.
- busy_o  output  1  high while in the GRANT state.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE and gnt_o to 0.
  - Round-robin pointer ptr is set to NUM_REQ-1, so requester 0 has highest priority after reset.
  - valid_o, last_o, busy_o are 0 and data_o is all zeros.
  - Reset asserted mid-packet aborts the packet immediately. No beat is accepted in the reset cycle.
- States:
  - IDLE: gnt_o is 0.
    - If |req_i is true, pick the first set req_i bit scanning ptr+1, ptr+2, … with wrap modulo NUM_REQ.
    - Register that bit as gnt_o and go to GRANT.
    - If no req_i bit is set, stay in IDLE.
  - GRANT: gnt_o is held constant.
    - A transfer happens when valid_o and ready_i are both high.
    - On a transfer with last_o=1: clear gnt_o, set ptr to the granted index, go to IDLE.
    - Any other cycle: stay in GRANT.
- Latency and throughput:
  - req_i rising while in IDLE in cycle T gives gnt_o in cycle T+1.
  - Grant-to-data path is combinational.
  - There is exactly one IDLE bubble cycle between consecutive packets.
- Datapath (combinational from gnt_o and the inputs):
  - valid_o = |(req_i & gnt_o).
  - data_o = bitwise OR over i of (data_i slice i AND replicated gnt_o[i]).
  - last_o = |(last_i & gnt_o) & valid_o.
  - busy_o = (state == GRANT).
- Boundary conditions:
  - Granted requester drops req_i mid-packet: grant is held and valid_o is 0 until req_i returns. There is no timeout.
  - ready_i low: the beat stalls and the grant is held. Requesters must keep data and last stable while req_i is high and ready_i is low.
  - Non-granted req_i or last_i activity during GRANT has no effect on outputs or state.
  - Single-beat packet (last_i=1 on the first beat) with ready_i=1 completes in one GRANT cycle.
  - Pointer wrap: if ptr = NUM_REQ-1, the scan starts at index 0.
  - Only the granted requester is a candidate. A requester that was just served gets lowest priority on the next arbitration.
- Invariants:
  - gnt_o is always zero or one-hot.
  - When gnt_o is 0, valid_o, last_o and data_o are all 0.

Test Plan:
- Reset then req_i=4'b1111 held, every beat last, ready_i=1 → gnt_o sequence 0001, 0, 0010, 0, 0100, 0, 1000, 0, 0001, with a transfer on each GRANT cycle.
- req_i=4'b0100, 3-beat packet with data 8'hA1, A2, A3 and last on the third beat, ready_i=1 → gnt_o=0100 for 3 cycles, data_o=A1, A2, A3, last_o only on the third beat, then IDLE.
- During the packet above, drive ready_i=0 for 2 cycles on beat 2 → data_o holds A2, valid_o=1, gnt_o unchanged, packet completes 2 cycles later.
- Granted requester 1 drops req_i for 3 cycles mid-packet while req_i[3]=1 → gnt_o stays 0010, valid_o=0, requester 3 is not granted until requester 1 sends last.
- Serve requester 3, then req_i=4'b1001 → next grant is 0001 (wrap-around). Serve requester 0, then req_i=4'b1001 → next grant is 1000.
- Assert reset while in GRANT on beat 2 of 4 → next cycle gnt_o=0, valid_o=0, busy_o=0. With req_i=4'b0110 afterwards, the first grant is 0010.
